array_multiplier_recon: RTL and testbench
=========================================

// Module: array_multiplier_recon
// PURPOSE
//   Unsigned pipelined shift-add array multiplier; the inverse of the array divider.
//   Reconstructs the dividend from divider results: P = Q*B + R, A_out = P >> FRAC_BITS.
//   Sits after array_divider, both as a result checker and as a general fixed-point multiplier.
//   One result per clock, no backpressure; pipeline depth is set by a parameter.
// PARAMETERS
//   DATAWIDTH            4   width of Q, B, R and A_out
//   FRAC_BITS            0   fractional bits; the product is shifted right by this amount for A_out
//   NUM_PIPELINE_STAGES  1   enabled register stages, 0..DATAWIDTH+1 (0 = fully combinational)
//   INSTANCE_ID          0   identifier only; no functional effect
// PORTS
//   clk         in   1            single clock; all registers on rising edge
//   rst         in   1            asynchronous, active-low reset
//   i_valid     in   1            input sample valid; continuous streaming allowed
//   Q           in   DATAWIDTH    multiplicand (quotient from the divider)
//   B           in   DATAWIDTH    multiplier (divisor)
//   R           in   DATAWIDTH    addend (remainder); any value is legal, R<B is not required
//   o_valid     out  1            result valid, aligned with P_out, A_out and o_overflow
//   P_out       out  2*DATAWIDTH  full product Q*B+R
//   A_out       out  DATAWIDTH    P_out[DATAWIDTH+FRAC_BITS-1:FRAC_BITS]
//   o_overflow  out  1            1 when any bit of P_out at index >= DATAWIDTH+FRAC_BITS is set
// BEHAVIOUR
//   - Reset (rst=0, asynchronous) clears every pipeline register.
//     o_valid, P_out, A_out and o_overflow read 0 until the first valid sample drains through.
//   - Stage chain has indices 0..DATAWIDTH.
//     Stage 0 is the input capture: acc0 = zero-extended R; Q, B and i_valid are captured with it.
//     Stage i+1 computes acc_{i+1} = acc_i + (Q[i] ? (B << i) : 0).
//     Q bits are consumed LSB first.
//   - Register mask STAGE_MASK[i] = (i < NUM_PIPELINE_STAGES).
//     A disabled stage is a wire. Latency = NUM_PIPELINE_STAGES cycles exactly.
//   - Each stage register carries {acc, Q, B, valid}; valid travels in lockstep with the data.
//     Registers load every cycle regardless of i_valid (no clock enable).
//     Downstream logic qualifies data with o_valid.
//   - Width rule: acc is 2*DATAWIDTH bits.
//     Max (2^W-1)^2 + (2^W-1) < 2^(2W), so no carry is lost and there is no wrap-around.
//   - A_out/o_overflow are combinational from the final acc.
//     With FRAC_BITS=0, overflow means P_out > 2^DATAWIDTH-1.
//   - B=0 -> P_out=R.  Q=0 -> P_out=R.
//   - Back-to-back i_valid: one result per cycle, in order. No bubbles are inserted or removed.
//   - Reset mid-stream: all in-flight samples are discarded, with o_valid=0 during reset.
//     The first post-reset result appears NUM_PIPELINE_STAGES cycles after its i_valid.
//   - NUM_PIPELINE_STAGES > DATAWIDTH+1, or FRAC_BITS > DATAWIDTH: $error at elaboration.
// STRUCTURE
//   - Package arith_pkg: function stage_mask(num, width) returning the enable mask.
//     The same function is usable by array_divider.
//   - Sub-module mul_stage_comb #(WIDTH, BIT_POS): purely combinational single add step.
//     Inputs in_acc, Q_in, B_in; output out_acc.
//     One instance per Q bit in a generate loop.
//   - Registers use the shared pipeline_stage #(WIDTH, ENABLE), with its async active-low reset.
//     Bundle width 4*DATAWIDTH+1.
// TESTING
//   1. W=4,F=0,NPS=1: Q=2,B=6,R=1,i_valid=1 -> after 1 cycle o_valid=1, P_out=13, A_out=13, o_overflow=0.
//   2. W=4,F=0: Q=3,B=5,R=2 -> P_out=17, A_out=1, o_overflow=1.
//      Q=15,B=15,R=15 -> P_out=240, o_overflow=1.
//   3. W=4,F=4,NPS=5: Q=8,B=2,R=0 -> after 5 cycles P_out=16, A_out=1, o_overflow=0
//      (round trip of divider A=1,B=2).
//   4. NPS=0: Q=7,B=3,R=2 -> same-cycle P_out=23, o_valid=i_valid.
//      Sweep NPS=0..5 and check latency equals NPS.
//   5. Stream 6 back-to-back samples, then one bubble, then 2 more (NPS=3).
//      o_valid pattern is 111111011, shifted by 3 cycles; values are in order.
//   6. Assert rst=0 with 3 samples in flight -> o_valid=0 and P_out=0 immediately (asynchronous).
//      After release, the next sample returns after NPS cycles.
//      Random regression: chain array_divider -> this block; A_out==A whenever the divisor is nonzero and o_overflow=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-pipeline helpers for the array multiplier and the array divider.
// stage_mask() decides which stages of a chain own a register.
package arith_pkg;

  localparam int MAX_STAGES = 64;

  // Bit i is set when stage i of a width-stage chain is registered.
  function automatic logic [MAX_STAGES-1:0] stage_mask(input int num, input int width);
    logic [MAX_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (i < width && i < num) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/mul_stage_comb.sv
// One shift-add step of the array multiplier: conditionally adds B shifted by BIT_POS.
// Purely combinational; the caller decides whether a register follows it.
module mul_stage_comb #(
  parameter int WIDTH   = 4,
  parameter int BIT_POS = 0
) (
  input  logic [2*WIDTH-1:0] in_acc,
  input  logic [WIDTH-1:0]   Q_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic [2*WIDTH-1:0] out_acc
);

  logic [2*WIDTH-1:0] partial;

  assign partial = Q_in[BIT_POS] ? ({{WIDTH{1'b0}}, B_in} << BIT_POS) : '0;
  assign out_acc = in_acc + partial;

  // Only one multiplicand bit is consumed here; the rest travel on to later steps.
  logic unused_q;
  assign unused_q = ^Q_in;

endmodule

// File: rtl/pipeline_stage.sv
// Optional pipeline register shared by the arithmetic chains.
// ENABLE=0 turns the stage into a plain wire.
module pipeline_stage #(
  parameter int WIDTH  = 1,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (ENABLE) begin : g_reg
    // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
    end
  end else begin : g_wire
    assign q = d;
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;
  end

endmodule

// File: rtl/array_multiplier_recon.sv
// Pipelined unsigned shift-add multiplier producing P = Q*B + R and A_out = P >> FRAC_BITS.
// Rebuilds the dividend from array_divider results; also usable as a fixed-point multiplier.
module array_multiplier_recon
  import arith_pkg::*;
#(
  parameter int DATAWIDTH           = 4,
  parameter int FRAC_BITS           = 0,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [DATAWIDTH-1:0]   Q,
  input  logic [DATAWIDTH-1:0]   B,
  input  logic [DATAWIDTH-1:0]   R,
  output logic                   o_valid,
  output logic [2*DATAWIDTH-1:0] P_out,
  output logic [DATAWIDTH-1:0]   A_out,
  output logic                   o_overflow
);

  localparam int AW = 2 * DATAWIDTH;
  localparam int BW = AW + 2 * DATAWIDTH + 1;
  localparam logic [MAX_STAGES-1:0] STAGE_MASK = stage_mask(NUM_PIPELINE_STAGES, DATAWIDTH + 1);

  if (NUM_PIPELINE_STAGES < 0 || NUM_PIPELINE_STAGES > DATAWIDTH + 1) begin : g_bad_stages
    $error("array_multiplier_recon: NUM_PIPELINE_STAGES must lie in 0..DATAWIDTH+1");
  end
  if (FRAC_BITS < 0 || FRAC_BITS > DATAWIDTH) begin : g_bad_frac
    $error("array_multiplier_recon: FRAC_BITS must lie in 0..DATAWIDTH");
  end
  if (DATAWIDTH + 1 > MAX_STAGES || INSTANCE_ID < 0) begin : g_bad_misc
    $error("array_multiplier_recon: DATAWIDTH too large or negative INSTANCE_ID");
  end

  // Each stage bundle is {acc, Q, B, valid}; stage 0 captures R as the initial accumulator.
  for (genvar k = 0; k <= DATAWIDTH; k++) begin : g_stage
    logic [BW-1:0] d;
    logic [BW-1:0] q;

    if (k == 0) begin : g_capture
      assign d = {{DATAWIDTH{1'b0}}, R, Q, B, i_valid};
    end else begin : g_add
      logic [AW-1:0]        prev_acc;
      logic [AW-1:0]        next_acc;
      logic [DATAWIDTH-1:0] prev_q;
      logic [DATAWIDTH-1:0] prev_b;
      logic                 prev_v;

      assign {prev_acc, prev_q, prev_b, prev_v} = g_stage[k-1].q;

      mul_stage_comb #(
        .WIDTH  (DATAWIDTH),
        .BIT_POS(k - 1)
      ) u_add (
        .in_acc (prev_acc),
        .Q_in   (prev_q),
        .B_in   (prev_b),
        .out_acc(next_acc)
      );

      assign d = {next_acc, prev_q, prev_b, prev_v};
    end

    pipeline_stage #(
      .WIDTH (BW),
      .ENABLE(STAGE_MASK[k])
    ) u_reg (
      .clk  (clk),
      .rst_n(rst),
      .d    (d),
      .q    (q)
    );
  end

  logic [DATAWIDTH-1:0] final_q;
  logic [DATAWIDTH-1:0] final_b;

  assign {P_out, final_q, final_b, o_valid} = g_stage[DATAWIDTH].q;

  // The shift by DATAWIDTH+FRAC_BITS may equal the full width, which correctly yields no overflow.
  assign A_out      = DATAWIDTH'(P_out >> FRAC_BITS);
  assign o_overflow = |(P_out >> (DATAWIDTH + FRAC_BITS));

  logic unused_tail;
  assign unused_tail = ^{final_q, final_b};

endmodule

// File: tb/tb_array_multiplier_recon.sv
// Self-checking bench: several multiplier configurations share one randomized stimulus stream
// and are compared every cycle against a delayed-history arithmetic model.
module tb_array_multiplier_recon;

  localparam int NCFG  = 8;
  localparam int HSIZE = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req;
  logic       i_valid;
  logic [7:0] q8, b8, r8;

  logic        v_act  [NCFG];
  logic [15:0] p_act  [NCFG];
  logic [7:0]  a_act  [NCFG];
  logic        of_act [NCFG];

  int hv [HSIZE];
  int hq [HSIZE];
  int hb [HSIZE];
  int hr [HSIZE];
  int cyc;
  int last_low;
  int total;
  int bad;

  always #5 clk = ~clk;

  // Configurations 0..5: W=4, F=0, NPS=0..5.
  for (genvar g = 0; g < 6; g++) begin : g_sweep
    logic [7:0] p;
    logic [3:0] a;
    logic       v, o;
    array_multiplier_recon #(
      .DATAWIDTH(4), .FRAC_BITS(0), .NUM_PIPELINE_STAGES(g), .INSTANCE_ID(g)
    ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid),
      .Q(q8[3:0]), .B(b8[3:0]), .R(r8[3:0]),
      .o_valid(v), .P_out(p), .A_out(a), .o_overflow(o)
    );
    assign v_act[g]  = v;
    assign p_act[g]  = {8'h00, p};
    assign a_act[g]  = {4'h0, a};
    assign of_act[g] = o;
  end

  logic [7:0] p6;
  logic [3:0] a6;
  logic       v6, o6;
  array_multiplier_recon #(
    .DATAWIDTH(4), .FRAC_BITS(4), .NUM_PIPELINE_STAGES(5), .INSTANCE_ID(6)
  ) dut_frac (
    .clk(clk), .rst(rst), .i_valid(i_valid),
    .Q(q8[3:0]), .B(b8[3:0]), .R(r8[3:0]),
    .o_valid(v6), .P_out(p6), .A_out(a6), .o_overflow(o6)
  );
  assign v_act[6]  = v6;
  assign p_act[6]  = {8'h00, p6};
  assign a_act[6]  = {4'h0, a6};
  assign of_act[6] = o6;

  logic [15:0] p7;
  logic [7:0]  a7;
  logic        v7, o7;
  array_multiplier_recon #(
    .DATAWIDTH(8), .FRAC_BITS(3), .NUM_PIPELINE_STAGES(9), .INSTANCE_ID(7)
  ) dut_wide (
    .clk(clk), .rst(rst), .i_valid(i_valid),
    .Q(q8), .B(b8), .R(r8),
    .o_valid(v7), .P_out(p7), .A_out(a7), .o_overflow(o7)
  );
  assign v_act[7]  = v7;
  assign p_act[7]  = p7;
  assign a_act[7]  = a7;
  assign of_act[7] = o7;

  function automatic int cfg_w(input int i);
    return (i == 7) ? 8 : 4;
  endfunction

  function automatic int cfg_f(input int i);
    return (i == 6) ? 4 : ((i == 7) ? 3 : 0);
  endfunction

  function automatic int cfg_n(input int i);
    return (i < 6) ? i : ((i == 6) ? 5 : 9);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] q, input logic [7:0] b, input logic [7:0] r);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HSIZE) begin
      $display("FAIL history_bound: got %0d, expected below %0d", cyc, HSIZE);
      $fatal(1, "cycle budget exhausted");
    end
    rst     = rst_req;
    i_valid = v;
    q8      = q;
    b8      = b;
    r8      = r;
    hv[cyc] = int'(v);
    hq[cyc] = int'(q);
    hb[cyc] = int'(b);
    hr[cyc] = int'(r);
    if (!rst) last_low = cyc;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Output in cycle c must equal the sample driven in cycle c-NPS, unless a reset cleared it.
  always @(negedge clk) begin
    int s, w, f, n, m, qv, bv, rv, pe, ve;
    if (cyc > 0) begin
      for (int i = 0; i < NCFG; i++) begin
        w = cfg_w(i);
        f = cfg_f(i);
        n = cfg_n(i);
        m = (1 << w) - 1;
        s = cyc - n;
        if (n > 0 && s <= last_low) begin
          ve = 0;
          pe = 0;
        end else begin
          ve = hv[s];
          qv = hq[s] & m;
          bv = hb[s] & m;
          rv = hr[s] & m;
          pe = qv * bv + rv;
        end
        check($sformatf("cfg%0d o_valid", i), 32'(v_act[i]), 32'(ve));
        check($sformatf("cfg%0d P_out", i), 32'(p_act[i]), 32'(pe));
        check($sformatf("cfg%0d A_out", i), 32'(a_act[i]), 32'((pe >> f) & m));
        check($sformatf("cfg%0d o_overflow", i), 32'(of_act[i]), 32'(((pe >> (w + f)) != 0) ? 1 : 0));
      end
    end
  end

  initial begin
    int          lat_a [6];
    int          lat;
    logic [31:0] p_at;
    logic [11:0] in_bits, seen, exp_bits;
    int          a_val, b_val;

    total    = 0;
    bad      = 0;
    cyc      = 0;
    last_low = 0;
    rst_req  = 1'b0;
    rst      = 1'b0;
    i_valid  = 1'b0;
    q8 = '0; b8 = '0; r8 = '0;
    hv[0] = 0; hq[0] = 0; hb[0] = 0; hr[0] = 0;

    repeat (3) drive(1'b0, 8'd0, 8'd0, 8'd0);
    #2;
    check("reset o_valid nps3", 32'(v_act[3]), 32'd0);
    check("reset P_out wide", 32'(p_act[7]), 32'd0);
    rst_req = 1'b1;
    repeat (10) drive_rand(1'b0);

    // NPS=1 single sample.
    drive(1'b1, 8'd2, 8'd6, 8'd1);
    drive_rand(1'b0);
    #2;
    check("nps1 valid", 32'(v_act[1]), 32'd1);
    check("nps1 P=13", 32'(p_act[1]), 32'd13);
    check("nps1 A=13", 32'(a_act[1]), 32'd13);
    check("nps1 ovf=0", 32'(of_act[1]), 32'd0);

    // Combinational overflow cases.
    drive(1'b1, 8'd3, 8'd5, 8'd2);
    #2;
    check("nps0 P=17", 32'(p_act[0]), 32'd17);
    check("nps0 A=1", 32'(a_act[0]), 32'd1);
    check("nps0 ovf 17", 32'(of_act[0]), 32'd1);
    drive(1'b1, 8'd15, 8'd15, 8'd15);
    #2;
    check("nps0 P=240", 32'(p_act[0]), 32'd240);
    check("nps0 ovf 240", 32'(of_act[0]), 32'd1);

    // Fixed-point round trip: divider A=1, B=2 with F=4 gives Q=8, R=0.
    drive(1'b1, 8'd8, 8'd2, 8'd0);
    repeat (5) drive_rand(1'b0);
    #2;
    check("frac valid", 32'(v_act[6]), 32'd1);
    check("frac P=16", 32'(p_act[6]), 32'd16);
    check("frac A=1", 32'(a_act[6]), 32'd1);
    check("frac ovf=0", 32'(of_act[6]), 32'd0);

    // Latency sweep NPS=0..5 from one isolated sample.
    repeat (10) drive_rand(1'b0);
    drive(1'b1, 8'd7, 8'd3, 8'd2);
    #2;
    check("nps0 same-cycle P=23", 32'(p_act[0]), 32'd23);
    check("nps0 valid follows input", 32'(v_act[0]), 32'(i_valid));
    for (int i = 0; i < 6; i++) lat_a[i] = -1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        drive_rand(1'b0);
        #2;
      end
      for (int i = 0; i < 6; i++) begin
        if (v_act[i] && lat_a[i] < 0) lat_a[i] = k;
      end
    end
    for (int i = 0; i < 6; i++) check($sformatf("latency nps%0d", i), 32'(lat_a[i]), 32'(i));

    // Stream 6 samples, a bubble, then 2 more through NPS=3.
    repeat (4) drive_rand(1'b0);
    in_bits = 12'b0001_1011_1111;
    seen    = '0;
    for (int k = 0; k < 12; k++) begin
      drive_rand(in_bits[k]);
      #2;
      seen[k] = v_act[3];
    end
    exp_bits = '0;
    for (int k = 3; k < 12; k++) exp_bits[k] = in_bits[k-3];
    check("stream valid pattern", 32'(seen), 32'(exp_bits));

    // Asynchronous reset with three samples in flight.
    repeat (4) drive_rand(1'b0);
    repeat (3) drive_rand(1'b1);
    #2;
    rst_req  = 1'b0;
    rst      = 1'b0;
    last_low = cyc;
    #1;
    check("async rst valid nps3", 32'(v_act[3]), 32'd0);
    check("async rst P nps3", 32'(p_act[3]), 32'd0);
    check("async rst valid wide", 32'(v_act[7]), 32'd0);
    check("async rst P wide", 32'(p_act[7]), 32'd0);
    repeat (2) drive_rand(1'b1);
    rst_req = 1'b1;
    drive(1'b1, 8'd9, 8'd11, 8'd4);
    #2;
    lat  = v_act[3] ? 0 : -1;
    p_at = 32'(p_act[3]);
    for (int k = 1; k <= 6; k++) begin
      drive_rand(1'b0);
      #2;
      if (v_act[3] && lat < 0) begin
        lat  = k;
        p_at = 32'(p_act[3]);
      end
    end
    check("post-reset latency", 32'(lat), 32'd3);
    check("post-reset P=103", p_at, 32'd103);

    // Random streaming regression.
    repeat (1500) drive_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    // Divider round trip: Q=A/B, R=A%B must rebuild A without overflow.
    repeat (200) begin
      a_val = int'($urandom_range(0, 15));
      b_val = int'($urandom_range(1, 15));
      drive(1'b1, 8'(a_val / b_val), 8'(b_val), 8'(a_val % b_val));
      #2;
      check("round trip A", 32'(a_act[0]), 32'(a_val));
      check("round trip ovf", 32'(of_act[0]), 32'd0);
    end

    repeat (12) drive_rand(1'b0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
